// File: rtl/ddc_agc_pkg.sv
// Shared types and helpers for the DDC automatic gain controller.
package ddc_agc_pkg;

    localparam int unsigned SHIFT_W = 8;
    localparam int unsigned LEAD_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_SETTLE,
        ST_DECIDE,
        ST_APPLY
    } state_e;

    // Largest useful right shift: input magnitude range minus output range.
    function automatic int unsigned max_shift(input int unsigned in_w, input int unsigned out_w);
        return in_w - out_w;
    endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Magnitude bit count of a signed peak; negative or zero peaks report 0.
module lead_one_detect
    import ddc_agc_pkg::*;
#(
    parameter int unsigned W = 34
) (
    input  logic [W-1:0]      data_i,
    output logic [LEAD_W-1:0] n_c
);

    always_comb begin
        n_c = '0;
        if (!data_i[W-1]) begin
            for (int i = 0; i < int'(W) - 1; i++) begin
                if (data_i[i]) n_c = LEAD_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/ddc_agc_ctrl.sv
// Window-based AGC sequencer: clears the peak detectors, measures, and derives the gain-stage shift.
module ddc_agc_ctrl
    import ddc_agc_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 34,
    parameter int unsigned OUTPUT_WIDTH = 18,
    parameter int unsigned ADJ_WIDTH    = 16,
    parameter int unsigned WIN_WIDTH    = 24,
    parameter int unsigned SETTLE_CYC   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   agc_en,
    input  logic [ADJ_WIDTH-1:0]   manual_adj,
    input  logic [WIN_WIDTH-1:0]   win_len,
    input  logic [3:0]             headroom,
    input  logic                   nd,
    input  logic [INPUT_WIDTH-1:0] max_in,
    output logic                   peak_clr,
    output logic [ADJ_WIDTH-1:0]   adjust,
    output logic                   adj_update,
    output logic [INPUT_WIDTH-1:0] peak_latched,
    output logic [LEAD_W-1:0]      lead_pos,
    output logic                   sat_flag,
    output logic                   busy
);

    localparam int unsigned          MAX_SHIFT = max_shift(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam logic [ADJ_WIDTH-1:0] MAX_ADJ   = ADJ_WIDTH'(MAX_SHIFT);
    localparam logic [WIN_WIDTH-1:0] SETTLE_LAST = WIN_WIDTH'(SETTLE_CYC - 1);

    state_e                 state_q, state_d;
    logic [WIN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIN_WIDTH-1:0]   shadow_q, shadow_d;
    logic [ADJ_WIDTH-1:0]   desired_q, desired_d;
    logic [ADJ_WIDTH-1:0]   adjust_q, adjust_d;
    logic                   peak_clr_q, peak_clr_d;
    logic                   adj_update_q, adj_update_d;
    logic [INPUT_WIDTH-1:0] peak_q, peak_d;
    logic [LEAD_W-1:0]      lead_q, lead_d;
    logic                   sat_q, sat_d;
    logic                   busy_q, busy_d;

    logic [LEAD_W-1:0]          lead_n;
    logic signed [SHIFT_W-1:0]  raw_s;
    logic                       over_c;
    logic [ADJ_WIDTH-1:0]       desired_c;
    logic [ADJ_WIDTH-1:0]       manual_c;

    lead_one_detect #(
        .W (INPUT_WIDTH)
    ) u_lod (
        .data_i (max_in),
        .n_c    (lead_n)
    );

    // Shift needed to bring the peak just under output full scale, clamped to the legal range.
    always_comb begin
        raw_s  = $signed(SHIFT_W'(lead_n) + SHIFT_W'(headroom) - SHIFT_W'(OUTPUT_WIDTH - 1));
        over_c = raw_s > $signed(SHIFT_W'(MAX_SHIFT));
        if (raw_s[SHIFT_W-1])
            desired_c = '0;
        else if (over_c)
            desired_c = MAX_ADJ;
        else
            desired_c = ADJ_WIDTH'($unsigned(raw_s));
        manual_c = (manual_adj > MAX_ADJ) ? MAX_ADJ : manual_adj;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        desired_d    = desired_q;
        adjust_d     = adjust_q;
        peak_clr_d   = 1'b0;
        adj_update_d = 1'b0;
        peak_d       = peak_q;
        lead_d       = lead_q;
        sat_d        = sat_q;

        // Dropping agc_en mid-window abandons it; APPLY still completes its own step.
        if (!agc_en && state_q != ST_IDLE && state_q != ST_APPLY) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    adjust_d = manual_c;
                    if (agc_en) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    peak_clr_d = 1'b1;
                    shadow_d   = (win_len == '0) ? WIN_WIDTH'(1) : win_len;
                    cnt_d      = '0;
                    sat_d      = 1'b0;
                    state_d    = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (nd) begin
                        if (cnt_q == shadow_q - WIN_WIDTH'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_SETTLE;
                        end else begin
                            cnt_d = cnt_q + WIN_WIDTH'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DECIDE;
                    end else begin
                        cnt_d = cnt_q + WIN_WIDTH'(1);
                    end
                end
                ST_DECIDE: begin
                    peak_d    = max_in;
                    lead_d    = lead_n;
                    desired_d = desired_c;
                    if (over_c) sat_d = 1'b1;
                    state_d   = ST_APPLY;
                end
                ST_APPLY: begin
                    // Fast attack, one-step decay per window.
                    if (desired_q > adjust_q) begin
                        adjust_d     = desired_q;
                        adj_update_d = 1'b1;
                    end else if (desired_q < adjust_q) begin
                        adjust_d     = adjust_q - ADJ_WIDTH'(1);
                        adj_update_d = 1'b1;
                    end
                    state_d = agc_en ? ST_CLEAR : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            desired_q    <= '0;
            adjust_q     <= '0;
            peak_clr_q   <= 1'b0;
            adj_update_q <= 1'b0;
            peak_q       <= '0;
            lead_q       <= '0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            desired_q    <= desired_d;
            adjust_q     <= adjust_d;
            peak_clr_q   <= peak_clr_d;
            adj_update_q <= adj_update_d;
            peak_q       <= peak_d;
            lead_q       <= lead_d;
            sat_q        <= sat_d;
            busy_q       <= busy_d;
        end
    end

    assign peak_clr     = peak_clr_q;
    assign adjust       = adjust_q;
    assign adj_update   = adj_update_q;
    assign peak_latched = peak_q;
    assign lead_pos     = lead_q;
    assign sat_flag     = sat_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ddc_agc_ctrl.sv
// Scoreboard bench for ddc_agc_ctrl: per-window expectations are queued and checked on adj_update.
module tb_ddc_agc_ctrl;

    localparam int unsigned IW = 34;
    localparam int unsigned AW = 16;
    localparam int unsigned WW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          agc_en = 1'b0;
    logic [AW-1:0] manual_adj = '0;
    logic [WW-1:0] win_len = '0;
    logic [3:0]    headroom = '0;
    logic          nd = 1'b0;
    logic [IW-1:0] max_in = '0;
    logic          peak_clr;
    logic [AW-1:0] adjust;
    logic          adj_update;
    logic [IW-1:0] peak_latched;
    logic [5:0]    lead_pos;
    logic          sat_flag;
    logic          busy;

    ddc_agc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .agc_en       (agc_en),
        .manual_adj   (manual_adj),
        .win_len      (win_len),
        .headroom     (headroom),
        .nd           (nd),
        .max_in       (max_in),
        .peak_clr     (peak_clr),
        .adjust       (adjust),
        .adj_update   (adj_update),
        .peak_latched (peak_latched),
        .lead_pos     (lead_pos),
        .sat_flag     (sat_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] adj;
        logic [5:0]    lead;
        logic [IW-1:0] peak;
        logic          sat;
        int            at;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] pw(input int b);
        logic [IW-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Monitor: every adj_update pulse must match the oldest queued window result.
    always @(negedge clk) begin
        if (rst && adj_update) begin : pop
            exp_t e;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_update: got adjust 0x%0h at cycle %0d expected no update", adjust, cyc);
            end else begin
                e = sbq.pop_front();
                chk("upd_adjust", 64'(adjust), 64'(e.adj));
                chk("upd_lead",   64'(lead_pos), 64'(e.lead));
                chk("upd_peak",   64'(peak_latched), 64'(e.peak));
                chk("upd_sat",    64'(sat_flag), 64'(e.sat));
                chk("upd_cycle",  64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic wait_clr();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (peak_clr) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL peak_clr_timeout: got no pulse expected pulse within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    // Called in the peak_clr cycle; the update lands 9 cycles later with win_len=4 and nd held high.
    task automatic setw(input logic [IW-1:0] mx, input logic [3:0] hr, input bit upd,
                        input logic [AW-1:0] eadj, input logic [5:0] elead, input bit esat);
        exp_t e;
        max_in   = mx;
        headroom = hr;
        if (upd) begin
            e.adj  = eadj;
            e.lead = elead;
            e.peak = mx;
            e.sat  = esat;
            e.at   = cyc + 9;
            sbq.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        manual_adj = 16'd7;
        win_len    = 24'd4;
        headroom   = 4'd1;
        repeat (2) @(negedge clk);
        chk("rst_adjust",   64'(adjust), 64'd0);
        chk("rst_peak_clr", 64'(peak_clr), 64'd0);
        chk("rst_update",   64'(adj_update), 64'd0);
        chk("rst_peak",     64'(peak_latched), 64'd0);
        chk("rst_lead",     64'(lead_pos), 64'd0);
        chk("rst_sat",      64'(sat_flag), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("man_adjust_7", 64'(adjust), 64'd7);
        chk("man_busy",     64'(busy), 64'd0);
        manual_adj = 16'd40;
        repeat (2) @(negedge clk);
        chk("man_clamp_16", 64'(adjust), 64'd16);

        manual_adj = 16'd0;
        nd         = 1'b1;
        agc_en     = 1'b1;

        wait_clr();
        chk("agc_busy", 64'(busy), 64'd1);
        setw(pw(30), 4'd1, 1'b1, 16'd15, 6'd31, 1'b0);
        @(negedge clk);
        chk("clr_single", 64'(peak_clr), 64'd0);

        wait_clr(); setw(pw(20), 4'd1, 1'b1, 16'd14, 6'd21, 1'b0);
        wait_clr(); setw(pw(20), 4'd1, 1'b1, 16'd13, 6'd21, 1'b0);
        wait_clr(); setw(pw(33), 4'd1, 1'b1, 16'd12, 6'd0, 1'b0);
        wait_clr(); setw('0,     4'd1, 1'b1, 16'd11, 6'd0, 1'b0);
        for (int a = 10; a >= 0; a--) begin
            wait_clr(); setw('0, 4'd1, 1'b1, AW'(a), 6'd0, 1'b0);
        end
        wait_clr(); setw('0, 4'd1, 1'b0, 16'd0, 6'd0, 1'b0);
        wait_clr();
        chk("floor_adjust", 64'(adjust), 64'd0);
        chk("floor_lead",   64'(lead_pos), 64'd0);

        setw(IW'(64'hFFFF_FFFF), 4'd15, 1'b1, 16'd16, 6'd32, 1'b1);
        wait_clr();
        chk("sat_cleared", 64'(sat_flag), 64'd0);
        setw(pw(30), 4'd1, 1'b1, 16'd15, 6'd31, 1'b0);

        wait_clr();
        manual_adj = 16'd3;
        max_in     = pw(30);
        headroom   = 4'd15;
        @(negedge clk);
        agc_en = 1'b0;
        @(negedge clk);
        chk("abort_busy",  64'(busy), 64'd0);
        chk("abort_hold",  64'(adjust), 64'd15);
        @(negedge clk);
        chk("abort_manual", 64'(adjust), 64'd3);
        repeat (15) @(negedge clk);

        headroom = 4'd1;
        agc_en   = 1'b1;
        wait_clr();
        repeat (5) @(negedge clk);
        chk("settle_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("arst_adjust",   64'(adjust), 64'd0);
        chk("arst_peak_clr", 64'(peak_clr), 64'd0);
        chk("arst_update",   64'(adj_update), 64'd0);
        chk("arst_peak",     64'(peak_latched), 64'd0);
        chk("arst_lead",     64'(lead_pos), 64'd0);
        chk("arst_sat",      64'(sat_flag), 64'd0);
        chk("arst_busy",     64'(busy), 64'd0);
        agc_en     = 1'b0;
        manual_adj = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending updates expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
